// File: rtl/atomrvcore_pkg.sv
// Shared types, sizes and helpers for the atomrvcore DCCM arbiter.
// The byte-lane width is derived from the 32-bit DCCM word.
package atomrvcore_pkg;

    localparam int NUM_PORTS      = 2;
    localparam int DCCM_DATAWIDTH = 32;
    localparam int BE_WIDTH       = DCCM_DATAWIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RMW_RD,
        RMW_WR
    } dccm_arb_state_e;

    function automatic logic [DCCM_DATAWIDTH-1:0] be_merge(
        input logic [DCCM_DATAWIDTH-1:0] old_data,
        input logic [DCCM_DATAWIDTH-1:0] new_data,
        input logic [BE_WIDTH-1:0]       be
    );
        logic [DCCM_DATAWIDTH-1:0] merged;
        merged = old_data;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/atomrvcore_prio_arb.sv
// Two-way fixed-priority arbiter: port 0 wins unless port 1 has lost
// STARVE_LIMIT consecutive arbitration cycles, which forces one port 1 grant.
module atomrvcore_prio_arb
    import atomrvcore_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [NUM_PORTS-1:0] valid_i,
    output logic [NUM_PORTS-1:0] grant_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          force_p1;

    always_comb begin
        grant_o      = '0;
        starve_cnt_d = starve_cnt_q;
        force_p1     = (starve_cnt_q == CW'(STARVE_LIMIT));
        if (en_i) begin
            if (valid_i[1] && (force_p1 || !valid_i[0])) begin
                grant_o[1] = 1'b1;
            end else if (valid_i[0]) begin
                grant_o[0] = 1'b1;
            end
            // A losing port 1 can only be below the limit, so no saturation needed.
            if (grant_o[1]) begin
                starve_cnt_d = '0;
            end else if (valid_i[1]) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/atomrvcore_dccm_arbiter.sv
// Shares the single-port, word-write-only DCCM between the LSU (port 0) and a
// DMA/debug master (port 1); sub-word stores become read-modify-write sequences.
module atomrvcore_dccm_arbiter
    import atomrvcore_pkg::*;
#(
    parameter int DATAWIDTH    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_PORTS-1:0]                 req_valid_i,
    output logic [NUM_PORTS-1:0]                 req_ready_o,
    input  logic [NUM_PORTS-1:0]                 req_we_i,
    input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]   req_be_i,
    input  logic [NUM_PORTS-1:0][DATAWIDTH-1:0]  req_addr_i,
    input  logic [NUM_PORTS-1:0][DATAWIDTH-1:0]  req_wdata_i,
    output logic [NUM_PORTS-1:0]                 rsp_valid_o,
    output logic [DATAWIDTH-1:0]                 rsp_rdata_o,
    output logic [DATAWIDTH-1:0]                 mem_addr_o,
    output logic                                 mem_rd_en_o,
    output logic                                 mem_wr_en_o,
    output logic [DATAWIDTH-1:0]                 mem_wdata_o,
    input  logic [DATAWIDTH-1:0]                 mem_rdata_i
);

    dccm_arb_state_e       state_q, state_d;
    logic                  owner_q, owner_d;
    logic [DATAWIDTH-1:0]  addr_q, addr_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATAWIDTH-1:0]  wdata_q, wdata_d;
    logic [DATAWIDTH-1:0]  rdata_q, rdata_d;

    logic [NUM_PORTS-1:0]  grant;
    logic                  sel;
    logic [DATAWIDTH-1:0]  grant_addr;
    logic [BE_WIDTH-1:0]   grant_be;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{req_addr_i[0][1:0], req_addr_i[1][1:0]};

    atomrvcore_prio_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (state_q == IDLE),
        .valid_i (req_valid_i),
        .grant_o (grant)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        mem_addr_o  = '0;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_wdata_o = '0;
        sel         = grant[1];
        grant_addr  = {req_addr_i[sel][DATAWIDTH-1:2], 2'b00};
        grant_be    = req_be_i[sel];

        unique case (state_q)
            IDLE: begin
                req_ready_o = grant;
                if (|grant) begin
                    mem_addr_o = grant_addr;
                    owner_d    = sel;
                    addr_d     = grant_addr;
                    if (!req_we_i[sel]) begin
                        mem_rd_en_o = 1'b1;
                        state_d     = RD_WAIT;
                    end else if (&grant_be) begin
                        mem_wr_en_o = 1'b1;
                        mem_wdata_o = req_wdata_i[sel];
                    end else if (|grant_be) begin
                        // Partial store: fetch the old word first, merge later.
                        mem_rd_en_o = 1'b1;
                        be_d        = grant_be;
                        wdata_d     = req_wdata_i[sel];
                        state_d     = RMW_RD;
                    end
                end
            end
            RD_WAIT: begin
                mem_addr_o           = addr_q;
                rsp_valid_o[owner_q] = 1'b1;
                rsp_rdata_o          = mem_rdata_i;
                state_d              = IDLE;
            end
            RMW_RD: begin
                mem_addr_o = addr_q;
                rdata_d    = mem_rdata_i;
                state_d    = RMW_WR;
            end
            RMW_WR: begin
                mem_addr_o  = addr_q;
                mem_wr_en_o = 1'b1;
                mem_wdata_o = be_merge(rdata_q, wdata_q, be_q);
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_atomrvcore_dccm_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_atomrvcore_dccm_arbiter;

    localparam int LIMIT = 4;

    logic             clk_i  = 1'b0;
    logic             rst_ni = 1'b0;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0]       req_we_i;
    logic [1:0][3:0]  req_be_i;
    logic [1:0][31:0] req_addr_i;
    logic [1:0][31:0] req_wdata_i;
    logic [1:0]       rsp_valid_o;
    logic [31:0]      rsp_rdata_o;
    logic [31:0]      mem_addr_o;
    logic             mem_rd_en_o;
    logic             mem_wr_en_o;
    logic [31:0]      mem_wdata_o;
    logic [31:0]      mem_rdata_i;

    logic [31:0] env_mem [256];
    logic [31:0] golden  [256];

    int checks = 0;
    int errors = 0;

    atomrvcore_dccm_arbiter #(
        .DATAWIDTH    (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_be_i    (req_be_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rd_en_o (mem_rd_en_o),
        .mem_wr_en_o (mem_wr_en_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Environment DCCM macro: synchronous read, full-word write.
    always @(posedge clk_i) begin
        if (mem_rd_en_o) mem_rdata_i <= env_mem[mem_addr_o[9:2]];
        if (mem_wr_en_o) env_mem[mem_addr_o[9:2]] <= mem_wdata_o;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int p, input logic v, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i[p] = v;
        req_we_i[p]    = we;
        req_be_i[p]    = be;
        req_addr_i[p]  = addr;
        req_wdata_i[p] = wdata;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        env_mem[idx] = val;
        golden[idx]  = val;
    endtask

    // Transaction-level reference: each accepted request schedules the
    // outputs of the cycles it occupies; free cycles arbitrate by rule.
    typedef struct {
        bit          rsp;
        bit          wr;
        int          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sched_t;

    sched_t      sched [int];
    sched_t      s;
    int          mcyc   = 0;
    int          starve = 0;
    int          win;
    logic [1:0]  e_ready, e_rsp;
    logic [31:0] e_rdata, e_addr, e_wdata, merged;
    logic        e_rd, e_wr;

    always @(negedge clk_i) begin
        mcyc++;
        e_ready = '0; e_rsp = '0; e_rdata = '0; e_addr = '0;
        e_wdata = '0; e_rd = 1'b0; e_wr = 1'b0;
        if (!rst_ni) begin
            sched.delete();
            starve = 0;
        end else if (sched.exists(mcyc)) begin
            s = sched[mcyc];
            sched.delete(mcyc);
            e_addr = s.addr;
            if (s.rsp) begin
                e_rsp[s.port] = 1'b1;
                e_rdata       = golden[s.addr[9:2]];
            end
            if (s.wr) begin
                merged = golden[s.addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (s.be[b]) merged[8*b +: 8] = s.wdata[8*b +: 8];
                e_wr    = 1'b1;
                e_wdata = merged;
                golden[s.addr[9:2]] = merged;
            end
        end else begin
            win = -1;
            if (req_valid_i[1] && (starve == LIMIT || !req_valid_i[0])) win = 1;
            else if (req_valid_i[0]) win = 0;
            if (win == 1) starve = 0;
            else if (req_valid_i[1]) starve++;
            if (win >= 0) begin
                e_ready[win] = 1'b1;
                e_addr = req_addr_i[win] & 32'hFFFF_FFFC;
                if (!req_we_i[win]) begin
                    e_rd = 1'b1;
                    sched[mcyc+1] = '{rsp: 1'b1, wr: 1'b0, port: win, addr: e_addr, wdata: '0, be: '0};
                end else if (req_be_i[win] == 4'hF) begin
                    e_wr    = 1'b1;
                    e_wdata = req_wdata_i[win];
                    golden[e_addr[9:2]] = req_wdata_i[win];
                end else if (req_be_i[win] != 4'h0) begin
                    e_rd = 1'b1;
                    sched[mcyc+1] = '{rsp: 1'b0, wr: 1'b0, port: win, addr: e_addr, wdata: '0, be: '0};
                    sched[mcyc+2] = '{rsp: 1'b0, wr: 1'b1, port: win, addr: e_addr,
                                      wdata: req_wdata_i[win], be: req_be_i[win]};
                end
            end
        end
        checkOutput("m_ready",     req_ready_o, e_ready);
        checkOutput("m_rsp_valid", rsp_valid_o, e_rsp);
        checkOutput("m_rsp_rdata", rsp_rdata_o, e_rdata);
        checkOutput("m_mem_addr",  mem_addr_o,  e_addr);
        checkOutput("m_rd_en",     mem_rd_en_o, e_rd);
        checkOutput("m_wr_en",     mem_wr_en_o, e_wr);
        checkOutput("m_wdata",     mem_wdata_o, e_wdata);
    end

    logic [1:0] acc;

    initial begin
        logic [31:0] v;
        req_valid_i = '0; req_we_i = '0; req_be_i = '0; req_addr_i = '0; req_wdata_i = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            env_mem[i] = v;
            golden[i]  = v;
        end

        // Reset state
        repeat (3) @(negedge clk_i);
        checkOutput("rst_ready", req_ready_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("rst_rdata", rsp_rdata_o, 0);
        checkOutput("rst_addr", mem_addr_o, 0);
        checkOutput("rst_rd", mem_rd_en_o, 0);
        checkOutput("rst_wr", mem_wr_en_o, 0);
        checkOutput("rst_wdata", mem_wdata_o, 0);
        tick();
        rst_ni = 1'b1;

        // Port 0 load
        tick();
        preload(32'h104 >> 2, 32'hDEADBEEF);
        applyStimulus(0, 1, 0, 4'h0, 32'h0000_0104, 0);
        @(negedge clk_i);
        checkOutput("ld_ready", req_ready_o, 2'b01);
        checkOutput("ld_rd", mem_rd_en_o, 1);
        checkOutput("ld_addr", mem_addr_o, 32'h104);
        tick();
        applyStimulus(0, 0, 0, 4'h0, 0, 0);
        @(negedge clk_i);
        checkOutput("ld_rsp_valid", rsp_valid_o, 2'b01);
        checkOutput("ld_rdata", rsp_rdata_o, 32'hDEADBEEF);

        // Port 1 partial store with port 0 waiting behind it
        tick();
        preload(32'h208 >> 2, 32'h11223344);
        applyStimulus(1, 1, 1, 4'b0010, 32'h208, 32'h0000_AB00);
        @(negedge clk_i);
        checkOutput("rmw_ready", req_ready_o, 2'b10);
        checkOutput("rmw_rd", mem_rd_en_o, 1);
        checkOutput("rmw_addr", mem_addr_o, 32'h208);
        tick();
        applyStimulus(1, 0, 0, 4'h0, 0, 0);
        applyStimulus(0, 1, 1, 4'hF, 32'h300, 32'hCAFEF00D);
        @(negedge clk_i);
        checkOutput("rmw_n1_ready", req_ready_o, 0);
        checkOutput("rmw_n1_wr", mem_wr_en_o, 0);
        tick();
        @(negedge clk_i);
        checkOutput("rmw_n2_ready", req_ready_o, 0);
        checkOutput("rmw_n2_wr", mem_wr_en_o, 1);
        checkOutput("rmw_n2_wdata", mem_wdata_o, 32'h1122AB44);
        checkOutput("rmw_n2_addr", mem_addr_o, 32'h208);
        tick();
        @(negedge clk_i);
        checkOutput("rmw_n3_ready", req_ready_o, 2'b01);
        checkOutput("rmw_n3_addr", mem_addr_o, 32'h300);
        checkOutput("rmw_n3_wdata", mem_wdata_o, 32'hCAFEF00D);
        tick();

        // Starvation guard: every fifth contested grant goes to port 1
        applyStimulus(0, 1, 1, 4'hF, 32'h40, 32'h0A0A0A0A);
        applyStimulus(1, 1, 1, 4'hF, 32'h80, 32'h5555AAAA);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            checkOutput("starve_grant", req_ready_o, (k % 5 == 4) ? 2'b10 : 2'b01);
            tick();
        end
        applyStimulus(0, 0, 0, 4'h0, 0, 0);
        applyStimulus(1, 0, 0, 4'h0, 0, 0);

        // Empty byte enables: accepted without any memory access
        applyStimulus(0, 1, 1, 4'h0, 32'h44, 32'hFFFFFFFF);
        @(negedge clk_i);
        checkOutput("be0_ready", req_ready_o, 2'b01);
        checkOutput("be0_rd", mem_rd_en_o, 0);
        checkOutput("be0_wr", mem_wr_en_o, 0);
        tick();

        // Back-to-back full stores
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 1, 4'hF, 32'(4 * k), 32'h01010101 * (k + 1));
            @(negedge clk_i);
            checkOutput("b2b_wr", mem_wr_en_o, 1);
            checkOutput("b2b_addr", mem_addr_o, 32'(4 * k));
            checkOutput("b2b_wdata", mem_wdata_o, 32'h01010101 * (k + 1));
            tick();
        end
        applyStimulus(0, 0, 0, 4'h0, 0, 0);

        // Reset during RMW_RD drops the pending write
        preload(4, 32'h12345678);
        applyStimulus(0, 1, 1, 4'b0001, 32'h10, 32'h000000EE);
        @(negedge clk_i);
        checkOutput("rstrmw_rd", mem_rd_en_o, 1);
        tick();
        applyStimulus(0, 0, 0, 4'h0, 0, 0);
        rst_ni = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            checkOutput("rstrmw_wr", mem_wr_en_o, 0);
            checkOutput("rstrmw_wdata", mem_wdata_o, 0);
            checkOutput("rstrmw_addr", mem_addr_o, 0);
            tick();
        end
        rst_ni = 1'b1;
        applyStimulus(0, 1, 0, 4'h0, 32'h10, 0);
        @(negedge clk_i);
        checkOutput("rstrmw_idle_ready", req_ready_o, 2'b01);
        tick();
        applyStimulus(0, 0, 0, 4'h0, 0, 0);
        @(negedge clk_i);
        checkOutput("rstrmw_mem_kept", rsp_rdata_o, 32'h12345678);
        tick();

        // Randomized traffic obeying valid/payload hold until ready
        acc = '0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid_i[p] || acc[p]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        int r;
                        logic [3:0] be;
                        r  = $urandom_range(0, 3);
                        be = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom);
                        applyStimulus(p, 1, 1'($urandom), be, 32'($urandom_range(0, 1023)), $urandom);
                    end else begin
                        applyStimulus(p, 0, 0, 4'h0, 0, 0);
                    end
                end
            end
            @(negedge clk_i);
            acc = req_ready_o;
            tick();
        end
        applyStimulus(0, 0, 0, 4'h0, 0, 0);
        applyStimulus(1, 0, 0, 4'h0, 0, 0);
        repeat (4) tick();

        for (int i = 0; i < 256; i++) checkOutput("mem_word", env_mem[i], golden[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
